// File: rtl/hack_pkg.sv
// Shared Hack fetch types: address/instruction widths, buffered fetch entry, fetch FSM states.
// Pure declarations; no latency or flow control of its own.
package hack_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_DATA_W = 16;

  typedef logic [HACK_ADDR_W-1:0] hack_addr_t;
  typedef logic [HACK_DATA_W-1:0] hack_instr_t;

  typedef struct packed {
    hack_instr_t instr;
    hack_addr_t  pc;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/hack_fetch_fifo.sv
// DEPTH-entry first-word-fall-through FIFO of fetch entries; head visible the cycle after push.
// No internal backpressure: the caller never pushes when full; flush drops contents and any same-cycle push.
module hack_fetch_fifo
  import hack_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_dat_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_eff = pop_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i)  wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_eff) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/hack_fetch_unit.sv
// Hack instruction fetch: drives 1-cycle ROM, buffers replies, delivers {instr, pc}; issue->valid in 2 cycles.
// Issue stalls when buffered + in-flight would exceed DEPTH; redirect flushes everything and reloads fp.
module hack_fetch_unit
  import hack_pkg::*;
#(
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int DATA_W = HACK_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd_en,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fp_q, fp_d;
  logic [ADDR_W-1:0] iss_pc_q;
  logic              inflight_q;
  fetch_state_t      state_q, state_d;

  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  fetch_entry_t      head;
  fetch_entry_t      push_dat;
  logic              pop, push, issue;

  assign pop = instr_valid & instr_ready;

  // The in-flight reply already owns a buffer slot, so it is counted before issuing another.
  assign occupancy = {1'b0, count} - (CNT_W + 1)'(pop) + (CNT_W + 1)'(inflight_q);
  assign issue     = reset & ~redirect & (occupancy < (CNT_W + 1)'(DEPTH));

  assign rom_rd_en = issue;
  assign rom_addr  = fp_q;

  assign push     = inflight_q & ~redirect & (state_q == RUN);
  assign push_dat = '{instr: rom_data, pc: iss_pc_q};

  always_comb begin
    fp_d = fp_q;
    if (redirect)   fp_d = redirect_addr;
    else if (issue) fp_d = fp_q + 1'b1;
  end

  always_comb begin
    state_d = RUN;
    if (redirect && inflight_q) state_d = DRAIN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fp_q       <= '0;
      iss_pc_q   <= '0;
      inflight_q <= 1'b0;
      state_q    <= RUN;
    end else begin
      fp_q       <= fp_d;
      inflight_q <= issue;
      state_q    <= state_d;
      if (issue) iss_pc_q <= fp_q;
    end
  end

  hack_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .flush_i    (redirect),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;

endmodule
